// File: rtl/riscv_mem_arbiter_if.sv
// Handshake bundle between the fetch port, the data port and the shared memory bus.
// The arbiter uses the slave view; the surrounding pipeline and bus slave use the master view.
interface riscv_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    // instruction-fetch port
    logic                imem_req_i;
    logic [XLEN-1:0]     imem_adr_i;
    logic                imem_ack_o;
    logic                imem_err_o;
    logic [XLEN-1:0]     imem_q_o;

    // data-memory port
    logic                dmem_req_i;
    logic [XLEN-1:0]     dmem_adr_i;
    logic [1:0]          dmem_size_i;
    logic                dmem_we_i;
    logic [XLEN-1:0]     dmem_d_i;
    logic                dmem_ack_o;
    logic                dmem_err_o;
    logic                dmem_misaligned_o;
    logic [XLEN-1:0]     dmem_q_o;

    // shared memory bus
    logic                mem_req_o;
    logic [XLEN-1:0]     mem_adr_o;
    logic                mem_we_o;
    logic [XLEN/8-1:0]   mem_be_o;
    logic [XLEN-1:0]     mem_d_o;
    logic                mem_ack_i;
    logic                mem_err_i;
    logic [XLEN-1:0]     mem_q_i;

    modport slave (
        input  imem_req_i, imem_adr_i,
        output imem_ack_o, imem_err_o, imem_q_o,
        input  dmem_req_i, dmem_adr_i, dmem_size_i, dmem_we_i, dmem_d_i,
        output dmem_ack_o, dmem_err_o, dmem_misaligned_o, dmem_q_o,
        output mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o,
        input  mem_ack_i, mem_err_i, mem_q_i
    );

    modport master (
        output imem_req_i, imem_adr_i,
        input  imem_ack_o, imem_err_o, imem_q_o,
        output dmem_req_i, dmem_adr_i, dmem_size_i, dmem_we_i, dmem_d_i,
        input  dmem_ack_o, dmem_err_o, dmem_misaligned_o, dmem_q_o,
        input  mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o,
        output mem_ack_i, mem_err_i, mem_q_i
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one request/acknowledge memory bus between instruction fetch and data access,
// aligning store lanes, generating byte enables and trapping misaligned data accesses.
module riscv_mem_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    riscv_mem_arbiter_if.slave   bus
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        MISAL = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               last_dmem_q, last_dmem_d;
    logic               mem_req_q, mem_req_d;
    logic [XLEN-1:0]    mem_adr_q, mem_adr_d;
    logic               mem_we_q, mem_we_d;
    logic [BE_W-1:0]    mem_be_q, mem_be_d;
    logic [XLEN-1:0]    mem_d_q, mem_d_d;

    logic               imem_ack, imem_err;
    logic               dmem_ack, dmem_err, dmem_misal;

    // ---------------- data-port lane decode ----------------
    logic [OFF_W-1:0]   d_off;
    logic [3:0]         d_nbytes;
    logic [BE_W-1:0]    d_be_base;
    logic [BE_W-1:0]    d_be;
    logic [XLEN-1:0]    d_lane_data;
    logic [XLEN-1:0]    d_adr_aligned;
    logic [XLEN-1:0]    i_adr_aligned;
    logic               d_misal;
    logic               grant_d, grant_i;
    logic               unused_imem_lsb;

    assign d_off         = bus.dmem_adr_i[OFF_W-1:0];
    assign d_adr_aligned = {bus.dmem_adr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign i_adr_aligned = {bus.imem_adr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_imem_lsb = ^bus.imem_adr_i[OFF_W-1:0];

    always_comb begin
        d_nbytes = 4'd1;
        unique case (bus.dmem_size_i)
            2'd0:    d_nbytes = 4'd1;
            2'd1:    d_nbytes = 4'd2;
            2'd2:    d_nbytes = 4'd4;
            default: d_nbytes = 4'd8;
        endcase
    end

    // Lane gi is enabled when it lies inside the access width, before shifting by the offset.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_base
        assign d_be_base[gi] = (4'(gi) < d_nbytes);
    end

    assign d_be        = d_be_base << d_off;
    assign d_lane_data = bus.dmem_d_i << {d_off, 3'b000};

    // A dword request on a 32-bit bus has no legal encoding, so it is always trapped.
    always_comb begin
        d_misal = 1'b0;
        unique case (bus.dmem_size_i)
            2'd0:    d_misal = 1'b0;
            2'd1:    d_misal = bus.dmem_adr_i[0];
            2'd2:    d_misal = |bus.dmem_adr_i[1:0];
            default: d_misal = (XLEN < 64) || (|bus.dmem_adr_i[2:0]);
        endcase
    end

    // Round-robin on conflict: the port not granted last wins.
    assign grant_d = bus.dmem_req_i && (!bus.imem_req_i || !last_dmem_q);
    assign grant_i = bus.imem_req_i && !grant_d;

    // ---------------- sequencer ----------------
    always_comb begin
        state_d     = state_q;
        last_dmem_d = last_dmem_q;
        mem_req_d   = mem_req_q;
        mem_adr_d   = mem_adr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_d_d     = mem_d_q;
        imem_ack    = 1'b0;
        imem_err    = 1'b0;
        dmem_ack    = 1'b0;
        dmem_err    = 1'b0;
        dmem_misal  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    // A trapped access still counts as a grant so a stream of
                    // misaligned data requests cannot starve instruction fetch.
                    last_dmem_d = 1'b1;
                    if (d_misal) begin
                        state_d = MISAL;
                    end else begin
                        state_d   = BUS_D;
                        mem_req_d = 1'b1;
                        mem_adr_d = d_adr_aligned;
                        mem_we_d  = bus.dmem_we_i;
                        mem_be_d  = d_be;
                        mem_d_d   = d_lane_data;
                    end
                end else if (grant_i) begin
                    last_dmem_d = 1'b0;
                    state_d     = BUS_I;
                    mem_req_d   = 1'b1;
                    mem_adr_d   = i_adr_aligned;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_d_d     = '0;
                end
            end
            BUS_I: begin
                if (bus.mem_ack_i || bus.mem_err_i) begin
                    imem_ack  = bus.mem_ack_i;
                    imem_err  = bus.mem_err_i && !bus.mem_ack_i;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            BUS_D: begin
                if (bus.mem_ack_i || bus.mem_err_i) begin
                    dmem_ack  = bus.mem_ack_i;
                    dmem_err  = bus.mem_err_i && !bus.mem_ack_i;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            MISAL: begin
                dmem_misal = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_dmem_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_adr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_dmem_q <= last_dmem_d;
            mem_req_q   <= mem_req_d;
            mem_adr_q   <= mem_adr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_d_q     <= mem_d_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.mem_req_o         = mem_req_q;
    assign bus.mem_adr_o         = mem_adr_q;
    assign bus.mem_we_o          = mem_we_q;
    assign bus.mem_be_o          = mem_be_q;
    assign bus.mem_d_o           = mem_d_q;

    assign bus.imem_ack_o        = imem_ack;
    assign bus.imem_err_o        = imem_err;
    assign bus.imem_q_o          = bus.mem_q_i;
    assign bus.dmem_ack_o        = dmem_ack;
    assign bus.dmem_err_o        = dmem_err;
    assign bus.dmem_misaligned_o = dmem_misal;
    assign bus.dmem_q_o          = bus.mem_q_i;

endmodule
